// File: rtl/regex_pkg.sv
// Purpose: shared symbol encodings and driver state type for the regex checker slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regex_pkg;

    localparam int SYM_W = 2;

    localparam logic [SYM_W-1:0] SYM_A = 2'b00;
    localparam logic [SYM_W-1:0] SYM_B = 2'b01;
    localparam logic [SYM_W-1:0] SYM_C = 2'b10;
    localparam logic [SYM_W-1:0] SYM_D = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SEND,
        ST_WAIT,
        ST_RESP
    } drv_state_t;

endpackage

// File: rtl/regex_sym_shifter.sv
// Purpose: loadable symbol shift register; presents symbol 0 and drops one symbol per shift.
// Latency: head reflects a load or shift on the cycle after the edge.
// Backpressure: none; shifts only when told to.
//
// Ports: clk, res_n (sync active-low), load/data_in (capture packed string),
//        shift (advance by one symbol), head (current lowest symbol).
module regex_sym_shifter
    import regex_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input  logic                       clk,
    input  logic                       res_n,
    input  logic                       load,
    input  logic                       shift,
    input  logic [SYM_W*MAX_LEN-1:0]   data_in,
    output logic [SYM_W-1:0]           head
);

    logic [SYM_W*MAX_LEN-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= data_in;
        end else if (shift) begin
            sr_q <= {{SYM_W{1'b0}}, sr_q[SYM_W*MAX_LEN-1:SYM_W]};
        end
    end

    assign head = sr_q[SYM_W-1:0];

endmodule

// File: rtl/regex_stream_driver.sv
// Purpose: streams a latched symbol string into the regex checker and returns its verdict.
// Latency: start to resp_valid is L+3 cycles when the checker raises done right after the last symbol.
// Backpressure: none; start is taken only in IDLE and dropped otherwise, busy flags occupancy.
//
// Ports: clk, res_n (sync active-low); host side start/str_in/len_in, busy,
//        resp_valid/match/timeout; checker side chk_res_n, symbol_in,
//        last_symbol, result, done. All outputs are registered.
// Optional build macro REGEX_DRV_TIMEOUT_EN adds a WAIT-state watchdog of
// TIMEOUT cycles; without it the driver waits for done indefinitely.
module regex_stream_driver
    import regex_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int TIMEOUT = 8
) (
    input  logic                      clk,
    input  logic                      res_n,
    input  logic                      start,
    input  logic [2*MAX_LEN-1:0]      str_in,
    input  logic [LEN_W-1:0]          len_in,
    output logic                      busy,
    output logic                      chk_res_n,
    output logic [1:0]                symbol_in,
    output logic                      last_symbol,
    input  logic                      result,
    input  logic                      done,
    output logic                      resp_valid,
    output logic                      match,
    output logic                      timeout
);

    drv_state_t         state_q, state_nx;
    logic [LEN_W-1:0]   len_q, len_clamped;
    logic [LEN_W-1:0]   idx_q, idx_nx;
    logic               accept;
    logic               tmo_hit;
    logic [SYM_W-1:0]   shf_head;

    logic               busy_d, chk_res_n_d, last_d, resp_d, match_d, tmo_d;
    logic [SYM_W-1:0]   sym_d;

    assign accept      = (state_q == ST_IDLE) && start && (len_in != '0);
    assign len_clamped = (len_in > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_in;

    regex_sym_shifter #(
        .MAX_LEN (MAX_LEN)
    ) u_shifter (
        .clk     (clk),
        .res_n   (res_n),
        .load    (accept),
        // Head is consumed into symbol_in on every edge that lands in SEND,
        // so advance on exactly those edges.
        .shift   (state_nx == ST_SEND),
        .data_in (str_in),
        .head    (shf_head)
    );

`ifdef REGEX_DRV_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    // Counts completed WAIT cycles; restarts on every WAIT entry.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q != ST_WAIT) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    assign tmo_hit = (state_q == ST_WAIT) && !done && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // State and index register
    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_nx;
            idx_q   <= idx_nx;
            if (accept) begin
                len_q <= len_clamped;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state_q;
        idx_nx   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_nx = ST_SEND;
                idx_nx   = '0;
            end
            ST_SEND: begin
                // idx_q is the symbol currently on symbol_in. idx can reach
                // len_q (max MAX_LEN) which LEN_W holds without wrapping.
                idx_nx = idx_q + LEN_W'(1);
                if (idx_q == len_q - LEN_W'(1)) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done || tmo_hit) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs, derived from the
    // upcoming state so every output is a flop with no input-to-output path.
    always_comb begin
        busy_d      = (state_nx != ST_IDLE);
        chk_res_n_d = (state_nx != ST_CLEAR);
        resp_d      = (state_nx == ST_RESP);
        sym_d       = SYM_A;
        last_d      = 1'b0;
        match_d     = match;
        tmo_d       = timeout;

        if (state_nx == ST_SEND) begin
            sym_d  = shf_head;
            last_d = (idx_nx == len_q - LEN_W'(1));
        end

        if (accept) begin
            match_d = 1'b0;
            tmo_d   = 1'b0;
        end else if ((state_q == ST_WAIT) && (state_nx == ST_RESP)) begin
            // done wins over a watchdog expiry in the same cycle
            match_d = done ? result : 1'b0;
            tmo_d   = !done;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (!res_n) begin
            busy        <= 1'b0;
            chk_res_n   <= 1'b0;
            symbol_in   <= SYM_A;
            last_symbol <= 1'b0;
            resp_valid  <= 1'b0;
            match       <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            busy        <= busy_d;
            chk_res_n   <= chk_res_n_d;
            symbol_in   <= sym_d;
            last_symbol <= last_d;
            resp_valid  <= resp_d;
            match       <= match_d;
            timeout     <= tmo_d;
        end
    end

endmodule

// File: tb/tb_regex_stream_driver.sv
// Purpose: directed self-checking bench for regex_stream_driver with a scripted checker.
// Latency: n/a.
// Backpressure: n/a.
module tb_regex_stream_driver;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;

    logic                 clk = 1'b0;
    logic                 res_n;
    logic                 start;
    logic [2*MAX_LEN-1:0] str_in;
    logic [LEN_W-1:0]     len_in;
    logic                 busy, chk_res_n, last_symbol, resp_valid, match, timeout;
    logic [1:0]           symbol_in;
    logic                 result, done;

    regex_stream_driver #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .res_n       (res_n),
        .start       (start),
        .str_in      (str_in),
        .len_in      (len_in),
        .busy        (busy),
        .chk_res_n   (chk_res_n),
        .symbol_in   (symbol_in),
        .last_symbol (last_symbol),
        .result      (result),
        .done        (done),
        .resp_valid  (resp_valid),
        .match       (match),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Per-run observations gathered by run_str
    int          edges, clr_cnt, nsym, last_cnt, last_pos, resp_cnt, lat;
    logic [31:0] got_w;
    logic        got_match, got_tmo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Issues one start and plays the checker: done/result raised dly cycles
    // after the cycle showing last_symbol (dly<0: never). With noise set,
    // a done pulse and a start pulse hit SEND and another start hits WAIT.
    task automatic run_str(input logic [31:0] s, input logic [4:0] l, input logic r,
                           input int dly, input bit noise, input int budget);
        int since_last;
        bit in_send, seen_last;
        int post;
        edges = 0; clr_cnt = 0; nsym = 0; last_cnt = 0; last_pos = -1;
        resp_cnt = 0; lat = -1; got_w = '0; got_match = 1'bx; got_tmo = 1'bx;
        since_last = -1; in_send = 0; seen_last = 0; post = 0;
        @(negedge clk);
        str_in = s; len_in = l; start = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            edges++;
            start = 1'b0; done = 1'b0; result = 1'b0;
            if (last_symbol) last_cnt++;
            if (!chk_res_n) begin
                clr_cnt++;
                in_send = 1;
            end else if (in_send && !seen_last) begin
                if (nsym < 16) got_w[2*nsym +: 2] = symbol_in;
                if (last_symbol) begin
                    seen_last = 1; last_pos = nsym; since_last = 0;
                end
                nsym++;
                if (noise && nsym == 2) begin done = 1'b1; result = 1'b1; end
                if (noise && nsym == 3) begin start = 1'b1; str_in = ~s; len_in = 5'd3; end
            end else if (seen_last) begin
                since_last++;
            end
            if (seen_last && dly >= 0 && since_last == dly) begin done = 1'b1; result = r; end
            if (noise && since_last == 1) start = 1'b1;
            if (resp_valid) begin
                resp_cnt++; lat = edges; got_match = match; got_tmo = timeout;
            end
            if (resp_cnt > 0) post++;
            if (post >= 3) break;
        end
        start = 1'b0; done = 1'b0; result = 1'b0;
    endtask

    initial begin
        res_n = 1'b0; start = 1'b0; str_in = '0; len_in = '0; result = 1'b0; done = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_chk_res_n", 32'(chk_res_n), 32'd0);
        chk("rst_symbol", 32'(symbol_in), 32'd0);
        chk("rst_last", 32'(last_symbol), 32'd0);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        res_n = 1'b1;
        @(negedge clk);
        chk("idle_chk_res_n", 32'(chk_res_n), 32'd1);

        // ABCDD, result 0: symbols 0,1,2,3,3 -> 0x3E4
        run_str(32'h0000_03E4, 5'd5, 1'b0, 1, 0, 40);
        chk("t1_syms", got_w, 32'h0000_03E4);
        chk("t1_nsym", 32'(nsym), 32'd5);
        chk("t1_last_cnt", 32'(last_cnt), 32'd1);
        chk("t1_last_pos", 32'(last_pos), 32'd4);
        chk("t1_resp_cnt", 32'(resp_cnt), 32'd1);
        chk("t1_match", 32'(got_match), 32'd0);
        chk("t1_latency", 32'(lat), 32'd8);

        // ABBBCAABD, result 1 -> 0x34254
        run_str(32'h0003_4254, 5'd9, 1'b1, 1, 0, 40);
        chk("t2_syms", got_w, 32'h0003_4254);
        chk("t2_nsym", 32'(nsym), 32'd9);
        chk("t2_clr_cycles", 32'(clr_cnt), 32'd1);
        chk("t2_resp_cnt", 32'(resp_cnt), 32'd1);
        chk("t2_match", 32'(got_match), 32'd1);
        chk("t2_latency", 32'(lat), 32'd12);
        chk("t2_match_hold", 32'(match), 32'd1);

        // len_in = 0: start ignored entirely
        begin
            int busy_hi, clr_lo, resp_hi;
            busy_hi = 0; clr_lo = 0; resp_hi = 0;
            @(negedge clk);
            str_in = 32'hFFFF_FFFF; len_in = 5'd0; start = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (busy) busy_hi++;
                if (!chk_res_n) clr_lo++;
                if (resp_valid) resp_hi++;
            end
            chk("t3_len0_busy", 32'(busy_hi), 32'd0);
            chk("t3_len0_clear", 32'(clr_lo), 32'd0);
            chk("t3_len0_resp", 32'(resp_hi), 32'd0);
            chk("t3_len0_match_hold", 32'(match), 32'd1);
        end

        // Reset during SEND of ABCDDD (0xFE4) while symbol 3 is on the bus
        begin
            int resp_hi;
            resp_hi = 0;
            @(negedge clk);
            str_in = 32'h0000_0FE4; len_in = 5'd6; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            chk("t4_sym3_before_rst", 32'(symbol_in), 32'd3);
            res_n = 1'b0;
            @(negedge clk);
            chk("t4_busy", 32'(busy), 32'd0);
            chk("t4_chk_res_n", 32'(chk_res_n), 32'd0);
            chk("t4_symbol", 32'(symbol_in), 32'd0);
            chk("t4_last", 32'(last_symbol), 32'd0);
            chk("t4_match", 32'(match), 32'd0);
            chk("t4_timeout", 32'(timeout), 32'd0);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (resp_valid) resp_hi++;
            end
            res_n = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (resp_valid) resp_hi++;
            end
            chk("t4_no_resp", 32'(resp_hi), 32'd0);
            chk("t4_idle_busy", 32'(busy), 32'd0);
            chk("t4_idle_chk_res_n", 32'(chk_res_n), 32'd1);
        end

        // ABBCAAD (0x3094) after reset, result 1
        run_str(32'h0000_3094, 5'd7, 1'b1, 1, 0, 40);
        chk("t5_syms", got_w, 32'h0000_3094);
        chk("t5_last_pos", 32'(last_pos), 32'd6);
        chk("t5_resp_cnt", 32'(resp_cnt), 32'd1);
        chk("t5_match", 32'(got_match), 32'd1);
        chk("t5_latency", 32'(lat), 32'd10);

        // len_in = 20 clamps to 16 symbols
        run_str(32'h1B1B_1B1B, 5'd20, 1'b0, 1, 0, 50);
        chk("t6_syms", got_w, 32'h1B1B_1B1B);
        chk("t6_nsym", 32'(nsym), 32'd16);
        chk("t6_last_cnt", 32'(last_cnt), 32'd1);
        chk("t6_last_pos", 32'(last_pos), 32'd15);
        chk("t6_latency", 32'(lat), 32'd19);

        // Stray start in SEND and WAIT, stray done in SEND; real done 3 cycles late
        run_str(32'h0000_3094, 5'd7, 1'b0, 3, 1, 40);
        chk("t7_syms", got_w, 32'h0000_3094);
        chk("t7_nsym", 32'(nsym), 32'd7);
        chk("t7_resp_cnt", 32'(resp_cnt), 32'd1);
        chk("t7_match", 32'(got_match), 32'd0);
        chk("t7_latency", 32'(lat), 32'd12);

        // Checker never answers: ABCDD
        run_str(32'h0000_03E4, 5'd5, 1'b0, -1, 0, 30);
`ifdef REGEX_DRV_TIMEOUT_EN
        chk("t8_resp_cnt", 32'(resp_cnt), 32'd1);
        chk("t8_timeout", 32'(got_tmo), 32'd1);
        chk("t8_match", 32'(got_match), 32'd0);
        chk("t8_latency", 32'(lat), 32'd15);
`else
        chk("t8_resp_cnt", 32'(resp_cnt), 32'd0);
        chk("t8_busy_stuck", 32'(busy), 32'd1);
        chk("t8_timeout", 32'(timeout), 32'd0);
`endif
        res_n = 1'b0;
        @(negedge clk);
        chk("t8_rst_busy", 32'(busy), 32'd0);
        res_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regex_stream_driver.md
# regex_stream_driver

Transmit side of the regex checker's symbol interface. Accepts a packed string of 2-bit symbols plus a length on a start pulse, clears the checker, streams one symbol per clock with `last_symbol` on the final one, then waits for the checker's `done` and returns `result` on a one-cycle response strobe. Sits between the host/command logic and the `regex` checker instance.

## Interface
Parameters:
- `MAX_LEN`, 16, maximum symbols per string
- `LEN_W`, `$clog2(MAX_LEN+1)`, width of length field
- `TIMEOUT`, 8, WAIT-state cycle limit (used only with `REGEX_DRV_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `res_n`  in  1  synchronous, active-low reset
- `start`  in  1  request pulse; sampled only in IDLE
- `str_in`  in  2*MAX_LEN  packed symbols; symbol i at `[2i+1:2i]`, i=0 sent first
- `len_in`  in  LEN_W  symbol count, sampled with `start`
- `busy`  out  1  high from cycle after accepted `start` through RESP cycle
- `chk_res_n`  out  1  synchronous active-low reset to checker
- `symbol_in`  out  2  symbol to checker (A=00, B=01, C=10, D=11)
- `last_symbol`  out  1  high with final symbol only
- `result`  in  1  checker match result
- `done`  in  1  checker completion flag
- `resp_valid`  out  1  one-cycle response strobe
- `match`  out  1  captured `result`, valid with `resp_valid`
- `timeout`  out  1  response due to watchdog, valid with `resp_valid`

## Operation
- States: IDLE, CLEAR, SEND, WAIT, RESP.
- IDLE: `start`=1 and `len_in`≠0 → latch `str_in`, length = min(`len_in`, MAX_LEN) → CLEAR. `len_in`=0 → start ignored, stay IDLE.
- CLEAR: `chk_res_n`=0 one cycle; index cleared → SEND.
- SEND: `symbol_in` = latched symbol[index]; `last_symbol`=1 when index = length-1; index++; after last symbol → WAIT. `done` ignored in SEND.
- WAIT: `symbol_in` holds 0, `last_symbol`=0. `done`=1 → capture `result` into `match`, `timeout`=0 → RESP.
- RESP: `resp_valid`=1 one cycle → IDLE. `match`/`timeout` hold until next accepted start.
- `start` outside IDLE ignored; no queuing. `str_in`/`len_in` changes after acceptance have no effect.
- All registered outputs; no combinational input-to-output paths.

## Timing
- Reset values: `busy`=0, `chk_res_n`=0 (while `res_n`=0; 1 in IDLE), `symbol_in`=00, `last_symbol`=0, `resp_valid`=0, `match`=0, `timeout`=0; state IDLE.
- `start` at edge T → CLEAR outputs after T; symbol 0 presented after T+1; symbol L-1 with `last_symbol` after T+L.
- Checker raising `done` the cycle after the last symbol (nominal) → `resp_valid` asserted two edges after last symbol edge. Latency start-to-`resp_valid` = L+3 cycles nominal.
- `done` in same cycle as WAIT entry edge is sampled in WAIT normally; no lost event.
- Reset mid-operation: next edge all outputs to reset values, state IDLE, checker held in reset; no `resp_valid`.
- Length wrap: index width LEN_W; length = MAX_LEN must not wrap before `last_symbol`.

## Configuration
- `REGEX_DRV_TIMEOUT_EN` defined: WAIT counter counts cycles; after TIMEOUT cycles without `done` → RESP with `match`=0, `timeout`=1. Counter clears on WAIT entry.
- Not defined: no counter; WAIT until `done` or reset; `timeout` tied 0.

## Structure
- Shared package `regex_pkg`: symbol encodings `SYM_A..SYM_D`, `SYM_W`=2, driver state enum.
- One sub-module: `regex_sym_shifter` — loadable 2*MAX_LEN shift register presenting symbol[0] and shifting by 2 bits per SEND cycle.

## Test plan
- ABCDD, len 5, model checker done=1/result=0 cycle after last → 5 symbols in order, `last_symbol` only on 5th D, `resp_valid` once, `match`=0, start-to-response 8 cycles.
- ABBBCAABD, len 9, model result=1 → `match`=1, `chk_res_n` low exactly one cycle before first A.
- `len_in`=0 with `start` → `busy` stays 0, no `chk_res_n` pulse; `len_in`=20 with MAX_LEN=16 → 16 symbols sent.
- `start` pulsed during SEND and WAIT → ignored; single response; `done` pulse during SEND ignored.
- `res_n` low during SEND at symbol 3 of ABCDDD → next edge all outputs reset, no `resp_valid`; following start of ABBCAAD completes normally.
- With `REGEX_DRV_TIMEOUT_EN`, checker never raises `done` → `resp_valid`=1, `timeout`=1, `match`=0 after 8 WAIT cycles; without macro, `busy` stays 1 indefinitely.
